// File: rtl/exe_unit_pkg.sv
// Shared types for the sequential execute unit.
// Opcode and controller state encodings.
package exe_unit_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_CMP  = 4'd1,
    OP_SET  = 4'd2,
    OP_CONV = 4'd3,
    OP_MUL  = 4'd4
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/exe_unit_seq_if.sv
// Request/result bundle of the execute unit.
// master drives requests, slave is the unit.
interface exe_unit_seq_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic [3:0]       i_oper;
  logic [WIDTH-1:0] i_argA;
  logic [WIDTH-1:0] i_argB;
  logic             i_clr;
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;
  logic             o_carry;
  logic             o_error;
  logic             o_err_sticky;

  modport master (
    output i_valid, i_oper, i_argA, i_argB, i_clr,
    input  o_ready, o_valid, o_result, o_carry,
    input  o_error, o_err_sticky
  );

  modport slave (
    input  i_valid, i_oper, i_argA, i_argB, i_clr,
    output o_ready, o_valid, o_result, o_carry,
    output o_error, o_err_sticky
  );
endinterface

// File: rtl/exe_mul_iter.sv
// Iterative unsigned shift-add multiplier, one bit per clock.
// done marks the edge that folds in the last multiplier bit.
module exe_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_nxt;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  // product is valid in the cycle done is high
  assign product = acc_nxt;
  assign done    = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/exe_unit_seq.sv
// Execute unit: single-cycle ADD/CMP/SET/CONV,
// iterative MUL through exe_mul_iter.
module exe_unit_seq
  import exe_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           i_clk,
  input logic           i_rsn,
  exe_unit_seq_if.slave bus
);
  localparam int IDXW = $clog2(WIDTH);
  localparam int LW   = WIDTH + 32;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e             state;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   r_c;
  logic               c_c;
  logic               e_c;
  logic [WIDTH-1:0]   mag;
  logic               b_oob;

  assign bus.o_ready = (state == ST_IDLE);
  assign accept      = bus.i_valid && (state == ST_IDLE);
  assign mul_start   = accept && (bus.i_oper == OP_MUL);

  assign mag   = {1'b0, bus.i_argA[WIDTH-2:0]};
  assign b_oob = LW'(bus.i_argB) >= LW'(WIDTH);

  always_comb begin
    r_c = '0;
    c_c = 1'b0;
    e_c = 1'b0;
    unique case (bus.i_oper)
      OP_ADD:
        {c_c, r_c} = {1'b0, bus.i_argA}
                   + {1'b0, bus.i_argB};
      OP_CMP:
        r_c = WIDTH'($signed(bus.i_argA)
                   < $signed(bus.i_argB));
      OP_SET:
        if (b_oob) begin
          r_c = bus.i_argA;
          e_c = 1'b1;
        end else begin
          r_c = bus.i_argA
              | (ONE << bus.i_argB[IDXW-1:0]);
        end
      OP_CONV:
        // sign-magnitude: 1000..0 is negative zero
        if (!bus.i_argA[WIDTH-1]) r_c = bus.i_argA;
        else if (mag == '0)       e_c = 1'b1;
        else                      r_c = ~mag + ONE;
      OP_MUL:
        r_c = '0;
      default:
        e_c = 1'b1;
    endcase
  end

  exe_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (i_clk),
    .rst     (i_rsn),
    .start   (mul_start),
    .a       (bus.i_argA),
    .b       (bus.i_argB),
    .done    (mul_done),
    .product (prod)
  );

  always_ff @(posedge i_clk or posedge i_rsn) begin
    if (i_rsn) begin
      state            <= ST_IDLE;
      bus.o_valid      <= 1'b0;
      bus.o_result     <= '0;
      bus.o_carry      <= 1'b0;
      bus.o_error      <= 1'b0;
      bus.o_err_sticky <= 1'b0;
    end else begin
      bus.o_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (mul_start) begin
            state <= ST_MUL;
          end else if (accept) begin
            bus.o_valid  <= 1'b1;
            bus.o_result <= r_c;
            bus.o_carry  <= c_c;
            bus.o_error  <= e_c;
          end
          if (accept && !mul_start && e_c)
            bus.o_err_sticky <= 1'b1;
          else if (bus.i_clr)
            bus.o_err_sticky <= 1'b0;
        end
        ST_MUL: begin
          if (mul_done) begin
            state        <= ST_IDLE;
            bus.o_valid  <= 1'b1;
            bus.o_result <= prod[WIDTH-1:0];
            bus.o_carry  <= |prod[2*WIDTH-1:WIDTH];
            bus.o_error  <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/exe_unit_seq.md
EXE_UNIT_SEQ -- requirements
Module: exe_unit_seq

Interface
REQ-001 Parameter SHALL be WIDTH, default 32: operand/result width, even, >= 8.
REQ-002 Derived constant SHALL be IDXW = $clog2(WIDTH): bit-index width for SET.
REQ-003 Port SHALL be i_clk  in  1  sole clock, rising-edge.
REQ-004 Port SHALL be i_rsn  in  1  reset, asynchronous, active-high.
REQ-005 Port SHALL be i_valid  in  1  request strobe.
REQ-006 Port SHALL be i_oper  in  4  opcode.
REQ-007 Port SHALL be i_argA  in  WIDTH  operand A.
REQ-008 Port SHALL be i_argB  in  WIDTH  operand B.
REQ-009 Port SHALL be i_clr  in  1  clear sticky error.
REQ-010 Port SHALL be o_ready  out  1  unit accepts a request this cycle.
REQ-011 Port SHALL be o_valid  out  1  result pulse, one cycle per accepted request.
REQ-012 Port SHALL be o_result  out  WIDTH  registered result.
REQ-013 Port SHALL be o_carry  out  1  registered carry/overflow.
REQ-014 Port SHALL be o_error  out  1  registered per-result error.
REQ-015 Port SHALL be o_err_sticky  out  1  OR of all o_error since last clear.

Function
REQ-016 A request SHALL be accepted on a rising edge where i_valid=1 and o_ready=1; otherwise inputs are ignored.
REQ-017 Opcodes: 0 ADD, 1 CMP, 2 SET, 3 CONV, 4 MUL; 5-15 illegal.
REQ-018 ADD: result = (A+B) mod 2^WIDTH, carry = bit WIDTH of the sum, error 0.
REQ-019 CMP: result = 1 if signed A < signed B else 0, carry 0, error 0.
REQ-020 SET: result = A with bit B[IDXW-1:0] set; error = 1 and result = A when B >= WIDTH; carry 0.
REQ-021 CONV: A sign-magnitude to two's complement; MSB=0 -> A unchanged; MSB=1, mag != 0 -> -mag; A = only MSB set (negative zero) -> result 0, error 1; carry 0.
REQ-022 MUL: unsigned iterative shift-add; result = low WIDTH bits of A*B; carry = 1 iff high WIDTH bits nonzero; error 0.
REQ-023 Illegal opcode: result 0, carry 0, error 1.
REQ-024 Single-cycle ops (0-3, illegal): accepted at edge k, outputs registered at edge k, o_valid = 1 for the cycle after edge k only; o_ready stays 1, so back-to-back acceptance every cycle is supported.
REQ-025 FSM states SHALL be IDLE and MUL; o_ready = 1 only in IDLE.
REQ-026 IDLE -> MUL on acceptance of opcode 4; operands latched, counter loaded with WIDTH.
REQ-027 In MUL, one multiplier bit (LSB first) SHALL be processed per edge; counter decrements; MUL -> IDLE on the edge where counter reaches 0, outputs registered that edge, o_valid high the following cycle (latency WIDTH edges).
REQ-028 Inputs (including i_valid) SHALL be ignored while in MUL.
REQ-029 o_result, o_carry, o_error SHALL hold their last values when o_valid = 0.
REQ-030 o_err_sticky set on any edge registering o_error=1; i_clr clears it; simultaneous set and clear -> set wins.

Reset
REQ-031 i_rsn=1 SHALL immediately force state IDLE, counter 0, o_valid 0, o_result 0, o_carry 0, o_error 0, o_err_sticky 0; o_ready 1 after release.
REQ-032 Reset during MUL SHALL abandon the operation with no o_valid pulse.

Structure
REQ-033 Package exe_unit_pkg SHALL hold the opcode enum (OP_ADD..OP_MUL) and state enum (ST_IDLE, ST_MUL).
REQ-034 Multiplier datapath (accumulator, shift registers, counter) SHALL be sub-module exe_mul_iter with start/done handshake; ADD/CMP/SET/CONV remain inline combinational logic ahead of the output register.

Verification (WIDTH=8)
REQ-035 ADD A=0xFF B=0x01 -> next cycle o_valid=1, o_result=0x00, o_carry=1.
REQ-036 SET A=0x00 B=0x09 -> o_result=0x00, o_error=1, o_err_sticky=1 until i_clr pulse.
REQ-037 CONV A=0x85 -> 0xFB, error 0; A=0x80 -> 0x00, error 1; CMP A=0x80 B=0x01 -> 0x01.
REQ-038 MUL A=0x10 B=0x20 -> o_ready low 8 cycles, o_valid 8 edges after acceptance, o_result=0x00, o_carry=1; i_valid pulses during MUL produce no extra results.
REQ-039 Back-to-back ADD, CMP, opcode 9 on consecutive cycles -> three consecutive o_valid pulses, third with o_error=1.
REQ-040 Assert i_rsn 3 cycles into MUL -> outputs zero immediately, no o_valid, o_ready=1 after release.
